// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared AES datapath types and GF(2^8) helpers.
//   state_t : full 128-bit AES state, column-major, row 0 byte in the column MSB
//   col_t   : one 32-bit state column
//   NB      : number of columns in the state
//   GF_POLY : low byte of the field polynomial x^8+x^4+x^3+x+1
//   xtime   : multiply a field element by 2
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  localparam int         NB      = 4;
  localparam logic [7:0] GF_POLY = 8'h1B;

  // Multiplying by x shifts left; when the x^7 term falls off the top the
  // polynomial is folded back in.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_comb.sv
// mix_column_comb
//   Purely combinational MixColumns transform of a single state column.
//   Optional feature macro: MIXCOL_INV_MIX_EN (adds the inv select and the
//   InvMixColumns matrix).
// Ports:
//   col_in  : input column, row 0 byte in [31:24]
//   inv     : (MIXCOL_INV_MIX_EN only) 1 selects InvMixColumns
//   col_out : transformed column, same byte layout
module mix_column_comb
  import aes_pkg::*;
(
  input  col_t col_in,
`ifdef MIXCOL_INV_MIX_EN
  input  logic inv,
`endif
  output col_t col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;
  col_t       fwd;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // Forward matrix rows {2,3,1,1} rotated right per row; 3a is built as 2a^a.
  always_comb begin
    fwd[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    fwd[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    fwd[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    fwd[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
  end

`ifdef MIXCOL_INV_MIX_EN
  logic [7:0] q0, q1, q2, q3;
  logic [7:0] e0, e1, e2, e3;
  logic [7:0] m9  [4];
  logic [7:0] m11 [4];
  logic [7:0] m13 [4];
  logic [7:0] m14 [4];
  col_t       invc;

  assign q0 = xtime(x0);
  assign q1 = xtime(x1);
  assign q2 = xtime(x2);
  assign q3 = xtime(x3);
  assign e0 = xtime(q0);
  assign e1 = xtime(q1);
  assign e2 = xtime(q2);
  assign e3 = xtime(q3);

  // Build 9/11/13/14 multiples of each byte from the 2x/4x/8x chain:
  // 9=8+1, 11=8+2+1, 13=8+4+1, 14=8+4+2.
  always_comb begin
    m9[0]  = e0 ^ a0;            m9[1]  = e1 ^ a1;
    m9[2]  = e2 ^ a2;            m9[3]  = e3 ^ a3;
    m11[0] = e0 ^ x0 ^ a0;       m11[1] = e1 ^ x1 ^ a1;
    m11[2] = e2 ^ x2 ^ a2;       m11[3] = e3 ^ x3 ^ a3;
    m13[0] = e0 ^ q0 ^ a0;       m13[1] = e1 ^ q1 ^ a1;
    m13[2] = e2 ^ q2 ^ a2;       m13[3] = e3 ^ q3 ^ a3;
    m14[0] = e0 ^ q0 ^ x0;       m14[1] = e1 ^ q1 ^ x1;
    m14[2] = e2 ^ q2 ^ x2;       m14[3] = e3 ^ q3 ^ x3;
  end

  // Inverse matrix rows {0e,0b,0d,09} rotated right per row.
  always_comb begin
    invc[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
    invc[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
    invc[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
    invc[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
  end

  assign col_out = inv ? invc : fwd;
`else
  assign col_out = fwd;
`endif

endmodule

// File: rtl/mixcolumns_iter.sv
// mixcolumns_iter
//   Iterative AES MixColumns stage: accepts a state, transforms
//   COLS_PER_CYCLE columns per BUSY cycle, then presents the result.
//   Optional feature macro: MIXCOL_INV_MIX_EN (adds inv input).
// Parameters:
//   COLS_PER_CYCLE : 1, 2 or 4 columns per BUSY cycle
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready / in_data    : input handshake and state
//   inv        : (MIXCOL_INV_MIX_EN only) latched with in_data, selects inverse
//   out_valid / out_ready / out_data : output handshake and result
module mixcolumns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef MIXCOL_INV_MIX_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // The counter value of the BUSY cycle that finishes column 3.
  localparam logic [1:0] LAST_CNT = 2'(NB - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  logic [1:0]            state;
  logic [1:0]            cnt;
  // Packed as columns: work[3] is column 0 (bits 127:96), work[0] is column 3.
  logic [NB-1:0][31:0]   work;
  logic [NB-1:0][31:0]   work_nx;
  col_t                  mixed   [COLS_PER_CYCLE];
  logic [1:0]            mix_idx [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_MIX_EN
  logic inv_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign mix_idx[g] = cnt + 2'(g);

    mix_column_comb u_mix (
      .col_in  (work[2'd3 - mix_idx[g]]),
`ifdef MIXCOL_INV_MIX_EN
      .inv     (inv_q),
`endif
      .col_out (mixed[g])
    );
  end

  // Splice the freshly mixed columns into a copy of the work register; the
  // untouched columns pass through unchanged.
  always_comb begin
    work_nx = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_nx[2'd3 - mix_idx[g]] = mixed[g];
    end
  end

  // Control FSM plus datapath registers. out_data is its own register so it
  // keeps the last result after the handshake even when a new state has
  // already been accepted into the work register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      out_data <= '0;
`ifdef MIXCOL_INV_MIX_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            cnt   <= '0;
            state <= BUSY;
`ifdef MIXCOL_INV_MIX_EN
            inv_q <= inv;
`endif
          end
        end
        BUSY: begin
          work <= work_nx;
          if (cnt == LAST_CNT) begin
            out_data <= work_nx;
            state    <= DONE;
          end else begin
            cnt <= cnt + CNT_STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mixcolumns_iter.sv
// tb_mixcolumns_iter
//   Directed bench for mixcolumns_iter. Three instances (1, 2 and 4 columns
//   per cycle) share the input side so every vector also sweeps the parameter.
module tb_mixcolumns_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
`ifdef MIXCOL_INV_MIX_EN
  logic         inv;
`endif

  logic         in_ready1, in_ready2, in_ready4;
  logic         out_valid1, out_valid2, out_valid4;
  logic [127:0] out_data1, out_data2, out_data4;

  int numChecks = 0;
  int numFails  = 0;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] BND_IN   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] BND_OUT  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  always #5 clk = ~clk;

  mixcolumns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data),
`ifdef MIXCOL_INV_MIX_EN
    .inv(inv),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
  );

  mixcolumns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data),
`ifdef MIXCOL_INV_MIX_EN
    .inv(inv),
`endif
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2)
  );

  mixcolumns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data),
`ifdef MIXCOL_INV_MIX_EN
    .inv(inv),
`endif
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one state for a single accept edge; returns at the negedge
  // following that edge with in_valid already dropped.
  task automatic applyStimulus(input logic [127:0] data);
    @(negedge clk);
    checkOutput("ready_before_accept", {in_ready1, in_ready2, in_ready4}, 3'b111);
    in_valid = 1'b1;
    in_data  = data;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Accept a state, check out_valid cycle by cycle against each instance's
  // latency, check the result, then complete the output handshake.
  task automatic runVector(input string tag, input logic [127:0] data,
                           input logic [127:0] expected, input bit release_out);
    applyStimulus(data);
    for (int k = 0; k <= 4; k++) begin
      checkOutput({tag, "_valid_timing"}, {out_valid1, out_valid2, out_valid4},
                  {k >= 4, k >= 2, k >= 1});
      if (k < 4) @(negedge clk);
    end
    checkOutput({tag, "_data_c1"}, out_data1, expected);
    checkOutput({tag, "_data_c2"}, out_data2, expected);
    checkOutput({tag, "_data_c4"}, out_data4, expected);
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, "_idle_after_ready"}, {in_ready1, in_ready2, in_ready4,
                  out_valid1, out_valid2, out_valid4}, 6'b111000);
      checkOutput({tag, "_data_kept"}, out_data1, expected);
    end
  endtask

  initial begin
    $display("[TB] mixcolumns_iter directed test starting");
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef MIXCOL_INV_MIX_EN
    inv       = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {in_ready1, in_ready2, in_ready4}, 3'b111);
    checkOutput("reset_valid", {out_valid1, out_valid2, out_valid4}, 3'b000);
    checkOutput("reset_data", out_data1 | out_data2 | out_data4, 128'h0);
    reset = 1'b0;

    // FIPS-197 vector across all three column widths.
    runVector("fips", FIPS_IN, FIPS_OUT, 1'b1);

    // Backpressure: hold out_ready low for 10 cycles with stray input pulses.
    runVector("bp", FIPS_IN, FIPS_OUT, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 128'h0123456789abcdef_fedcba9876543210 ^ 128'(i);
      @(negedge clk);
      checkOutput("bp_valid_held", {out_valid1, out_valid2, out_valid4}, 3'b111);
      checkOutput("bp_not_ready", {in_ready1, in_ready2, in_ready4}, 3'b000);
      checkOutput("bp_data_c1", out_data1, FIPS_OUT);
      checkOutput("bp_data_c4", out_data4, FIPS_OUT);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_idle_after_ready", {in_ready1, in_ready2, in_ready4,
                out_valid1, out_valid2, out_valid4}, 6'b111000);

    // Next accept after backpressure uses the boundary-column vector.
    runVector("bnd", BND_IN, BND_OUT, 1'b1);

    // Reset during the second BUSY cycle of the single-column instance.
    applyStimulus(FIPS_IN);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_mid_valid", {out_valid1, out_valid2, out_valid4}, 3'b000);
    checkOutput("rst_mid_ready", {in_ready1, in_ready2, in_ready4}, 3'b111);
    checkOutput("rst_mid_data", out_data1 | out_data2 | out_data4, 128'h0);
    runVector("fips_after_rst", FIPS_IN, FIPS_OUT, 1'b1);

`ifdef MIXCOL_INV_MIX_EN
    inv = 1'b1;
    runVector("inv", FIPS_OUT, FIPS_IN, 1'b1);
    inv = 1'b0;
    runVector("fwd_after_inv", FIPS_IN, FIPS_OUT, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/mixcolumns_iter.md
Name: mixcolumns_iter

Overview:
- Iterative AES MixColumns stage for the round datapath.
- Accepts a 128-bit state from ShiftRows over a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock using GF(2^8) xtime multiplication with polynomial x^8+x^4+x^3+x+1 (0x1B).
- Returns the result to AddRoundKey over a second valid/ready handshake.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state.
- in_data  input  128  AES state, column-major: column c = in_data[127-32c -: 32], row 0 byte is the column MSB.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  MixColumns result, same byte layout as in_data.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- FSM states: IDLE, BUSY, DONE. Reset value is IDLE.
- Reset values: in_ready=1, out_valid=0, out_data=0, column counter=0, work register=0.
- in_ready = (state==IDLE). It depends on state only, never combinationally on in_valid.
- IDLE: on in_valid && in_ready, latch in_data into the work register, clear the counter, go to BUSY. Otherwise stay in IDLE.
- BUSY: each cycle, replace columns cnt..cnt+COLS_PER_CYCLE-1 of the work register with their mixed values, then cnt += COLS_PER_CYCLE.
- BUSY exit: the cycle that processes column 3 transitions to DONE.
- Forward column transform: r0'=2a0^3a1^a2^a3, r1'=a0^2a1^3a2^a3, r2'=a0^a1^2a2^3a3, r3'=3a0^a1^a2^2a3.
- GF arithmetic: 2x = xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0), truncated to 8 bits; 3x = xtime(x)^x.
- Latency: out_valid rises 4/COLS_PER_CYCLE cycles after the input-accept edge.
- DONE: out_valid=1 and out_data = work register. Both are held stable while out_valid && !out_ready.
- DONE exit: on out_ready, go to IDLE. out_valid deasserts on the next edge; out_data keeps its last value.
- Minimum block interval: 4/COLS_PER_CYCLE + 2 cycles.
- in_valid during BUSY or DONE is ignored; no input is captured.
- out_ready outside DONE has no effect.
- Reset mid-operation: the in-flight state is discarded, all outputs return to their reset values, and the block is in IDLE on the next cycle.
- Counter: 2 bits. It resets to 0 on every accept and never wraps inside a block.

Optional Feature:
- Macro: MIXCOL_INV_MIX_EN.
- With the macro defined:
  - Adds input port inv (1 bit), sampled and latched with in_data on accept.
  - When the latched inv=1, BUSY applies the InvMixColumns matrix: row0 {0e,0b,0d,09}, rotated right one position per row.
  - Constants 9/11/13/14 are built from xtime chains (x^3 terms) plus XOR.
  - Latency and handshake are unchanged.
- Without the macro: the inv port does not exist and only the forward transform is built.

Decomposition:
- Shared package aes_pkg holds:
  - typedefs state_t (logic [127:0]) and col_t (logic [31:0]);
  - constants NB=4 and GF_POLY=8'h1B;
  - function xtime.
- Natural sub-module: mix_column_comb. It is a purely combinational single-column transform (col_t in, col_t out, plus inv input under MIXCOL_INV_MIX_EN).
- mixcolumns_iter instantiates COLS_PER_CYCLE copies of mix_column_comb and owns the FSM, counter and work register.

Test Plan:
- FIPS-197 vector: accept state with columns db135345, f20a225c, 01010101, c6c6c6c6 -> out_data columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6. With COLS_PER_CYCLE=1, out_valid rises exactly 4 cycles after accept.
- Boundary columns: input columns d4d4d4d5, 2d26314c, 00000000, ffffffff -> d5d5d7d6, 4d7ebdf8, 00000000, ffffffff.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data and out_valid stay stable, in_ready=0 throughout, and in_valid pulses are ignored. Then out_ready=1 -> IDLE next cycle, and the next accept succeeds.
- Reset mid-BUSY: assert reset in the 2nd BUSY cycle -> next cycle out_valid=0, out_data=0, in_ready=1. A fresh FIPS vector afterwards produces the correct result.
- Parameter sweep: repeat the first scenario with COLS_PER_CYCLE=2 and 4 -> identical data, with latency 2 and 1 cycles respectively.
- With MIXCOL_INV_MIX_EN: accept columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6 with inv=1 -> db135345, f20a225c, 01010101, c6c6c6c6.
